// File: rtl/seg_scan_ctrl.sv
// Purpose : multiplexed 4-digit seven-segment scan controller. A load is held in a shadow
//           set and becomes the displayed (active) set only at a frame boundary.
// Latency : outputs are decoded from registered state only. A load shows from digit 0 of the
//           first frame whose boundary edge comes after the load edge.
// Backpressure: none. A load is always accepted, and a newer load overwrites an unapplied one.
// Ports   : clk/reset (sync, active-high); value_in/en_in/lzb_in/load feed the shadow set;
//           digit_val/digit_sel drive the decoder; frame_done pulses on the frame's last cycle;
//           pending flags shadow data that is waiting for a boundary.
module seg_scan_ctrl #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value_in,
    input  logic [3:0]  en_in,
    input  logic        lzb_in,
    input  logic        load,
    output logic [3:0]  digit_val,
    output logic [3:0]  digit_sel,
    output logic        frame_done,
    output logic        pending
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic          tick;
    logic          boundary;

    logic [15:0]   act_value;
    logic [3:0]    act_en;
    logic          act_lzb;
    logic [15:0]   shd_value;
    logic [3:0]    shd_en;
    logic          shd_lzb;

    assign tick     = (cnt == CW'(REFRESH_DIV - 1));
    assign boundary = tick && (idx == 2'd3);

    // Prescaler and digit index.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            idx <= 2'd0;
        end else if (tick) begin
            cnt <= '0;
            idx <= idx + 2'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Shadow/active sets. At a boundary, the transfer reads the old shadow. A load on that
    // same edge then refills the shadow, so pending stays set.
    always_ff @(posedge clk) begin
        if (reset) begin
            act_value <= 16'h0000;
            act_en    <= 4'b1111;
            act_lzb   <= 1'b0;
            shd_value <= 16'h0000;
            shd_en    <= 4'b1111;
            shd_lzb   <= 1'b0;
            pending   <= 1'b0;
        end else begin
            if (boundary && pending) begin
                act_value <= shd_value;
                act_en    <= shd_en;
                act_lzb   <= shd_lzb;
            end
            if (load) begin
                shd_value <= value_in;
                shd_en    <= en_in;
                shd_lzb   <= lzb_in;
                pending   <= 1'b1;
            end else if (boundary) begin
                pending   <= 1'b0;
            end
        end
    end

    // Output decode. It uses only idx, cnt and the active set, all of which are registered.
    logic upper_zero;
    logic shown;

    always_comb begin
        upper_zero = 1'b0;
        case (idx)
            2'd1:    upper_zero = (act_value[15:4]  == 12'h000);
            2'd2:    upper_zero = (act_value[15:8]  == 8'h00);
            2'd3:    upper_zero = (act_value[15:12] == 4'h0);
            default: upper_zero = 1'b0;   // digit 0 is never blanked
        endcase
    end

    always_comb begin
        shown      = act_en[idx] && !(act_lzb && upper_zero);
        digit_val  = act_value[{idx, 2'b00} +: 4];
        digit_sel  = shown ? (4'b0001 << idx) : 4'b0000;
        frame_done = boundary;
    end

endmodule
